// File: rtl/ycbcr2rgb565_pkg.sv
// Shared constants, control struct and arithmetic helpers for the YCbCr -> RGB565 converter.
// The dither tables are only consulted when YCBCR2RGB_DITHER_EN is defined.
package ycbcr2rgb565_pkg;

    localparam int unsigned COEF_R_CR = 359;
    localparam int unsigned COEF_G_CB = 88;
    localparam int unsigned COEF_G_CR = 183;
    localparam int unsigned COEF_B_CB = 454;

    localparam logic [17:0] OFFS_R = 18'd45952;
    localparam logic [17:0] OFFS_G = 18'd34688;
    localparam logic [17:0] OFFS_B = 18'd58112;

    localparam int CTRL_DELAY = 3;

    // Indexed by {row, col}; entry 0 is the least significant element.
    localparam logic [3:0][2:0] DITHER_RB = {3'd2, 3'd6, 3'd4, 3'd0};
    localparam logic [3:0][1:0] DITHER_G  = {2'd1, 2'd3, 2'd2, 2'd0};

    typedef struct packed {
        logic vsync;
        logic hsync;
        logic de;
    } ctrl_t;

    function automatic logic [7:0] clamp8(input logic signed [17:0] s);
        logic [7:0] v;
        if (s[17])
            v = 8'd0;
        else if (s[16])
            v = 8'hFF;
        else
            v = s[15:8];
        return v;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [2:0] off);
        logic [8:0] t;
        t = {1'b0, v} + {6'd0, off};
        return t[8] ? 8'hFF : t[7:0];
    endfunction

    function automatic logic [4:0] to_rb5(input logic signed [17:0] s, input logic [2:0] off);
        logic [7:0] v;
        v = sat_add8(clamp8(s), off);
        return v[7:3];
    endfunction

    function automatic logic [5:0] to_g6(input logic signed [17:0] s, input logic [1:0] off);
        logic [7:0] v;
        v = sat_add8(clamp8(s), {1'b0, off});
        return v[7:2];
    endfunction

endpackage

// File: rtl/ycbcr2rgb565_if.sv
// Video bus for the YCbCr -> RGB565 converter: YCbCr pixel plus sync in, RGB565 plus sync out.
// The source/sink side uses master; the converter uses slave.
interface ycbcr2rgb565_if;
    logic       pre_frame_vsync;
    logic       pre_frame_hsync;
    logic       pre_frame_de;
    logic [7:0] img_y;
    logic [7:0] img_cb;
    logic [7:0] img_cr;
    logic       post_frame_vsync;
    logic       post_frame_hsync;
    logic       post_frame_de;
    logic [4:0] img_red;
    logic [5:0] img_green;
    logic [4:0] img_blue;

    modport master (
        output pre_frame_vsync, pre_frame_hsync, pre_frame_de, img_y, img_cb, img_cr,
        input  post_frame_vsync, post_frame_hsync, post_frame_de, img_red, img_green, img_blue
    );

    modport slave (
        input  pre_frame_vsync, pre_frame_hsync, pre_frame_de, img_y, img_cb, img_cr,
        output post_frame_vsync, post_frame_hsync, post_frame_de, img_red, img_green, img_blue
    );
endinterface

// File: rtl/ycbcr2rgb565_dither.sv
// 2x2 ordered-dither position tracker and offset lookup, present only when YCBCR2RGB_DITHER_EN
// is defined; the file is empty in the default build.
`ifdef YCBCR2RGB_DITHER_EN
module ycbcr2rgb_dither
    import ycbcr2rgb565_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       de,
    input  logic [1:0] pos_lookup,
    output logic [1:0] pos,
    output logic [2:0] off_rb,
    output logic [1:0] off_g
);

    logic row_reg;
    logic col_reg;
    logic de_prev_reg;
    logic vsync_prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_reg        <= 1'b0;
            col_reg        <= 1'b0;
            de_prev_reg    <= 1'b0;
            vsync_prev_reg <= 1'b0;
        end else begin
            de_prev_reg    <= de;
            vsync_prev_reg <= vsync;
            col_reg        <= de ? ~col_reg : 1'b0;
            // A new frame wins over an end-of-line in the same cycle.
            if (vsync && !vsync_prev_reg)
                row_reg <= 1'b0;
            else if (de_prev_reg && !de)
                row_reg <= ~row_reg;
        end
    end

    assign pos    = {row_reg, col_reg};
    assign off_rb = DITHER_RB[pos_lookup];
    assign off_g  = DITHER_G[pos_lookup];

endmodule
`endif

// File: rtl/ycbcr2rgb565.sv
// Three-stage YCbCr (8-bit) to RGB565 converter with saturation and 3-cycle sync alignment.
// Define YCBCR2RGB_DITHER_EN to add 2x2 ordered dithering ahead of the 565 truncation.
module ycbcr2rgb565
    import ycbcr2rgb565_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    ycbcr2rgb565_if.slave video
);

    logic [16:0]        y256_reg, cr359_reg, cb88_reg, cr183_reg, cb454_reg;
    logic signed [17:0] sum_r_reg, sum_g_reg, sum_b_reg;
    logic signed [17:0] sum_r_next, sum_g_next, sum_b_next;
    logic [4:0]         red_reg, blue_reg;
    logic [5:0]         green_reg;
    logic [2:0]         off_rb;
    logic [1:0]         off_g;
    ctrl_t              ctrl_in;
    ctrl_t              ctrl_pipe [CTRL_DELAY];

    assign ctrl_in = '{vsync: video.pre_frame_vsync,
                       hsync: video.pre_frame_hsync,
                       de:    video.pre_frame_de};

    genvar gi;
    generate
        for (gi = 0; gi < CTRL_DELAY; gi++) begin : g_ctrl
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    ctrl_pipe[gi] <= '0;
                else if (gi == 0)
                    ctrl_pipe[gi] <= ctrl_in;
                else
                    ctrl_pipe[gi] <= ctrl_pipe[(gi == 0) ? 0 : gi - 1];
            end
        end
    endgenerate

    // Stage 1: unsigned products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y256_reg  <= '0;
            cr359_reg <= '0;
            cb88_reg  <= '0;
            cr183_reg <= '0;
            cb454_reg <= '0;
        end else begin
            y256_reg  <= {1'b0, video.img_y, 8'd0};
            cr359_reg <= 17'(video.img_cr) * 17'(COEF_R_CR);
            cb88_reg  <= 17'(video.img_cb) * 17'(COEF_G_CB);
            cr183_reg <= 17'(video.img_cr) * 17'(COEF_G_CR);
            cb454_reg <= 17'(video.img_cb) * 17'(COEF_B_CB);
        end
    end

    // Stage 2: signed sums including the chroma offset constants.
    always_comb begin
        sum_r_next = $signed({1'b0, y256_reg}) + $signed({1'b0, cr359_reg}) - $signed(OFFS_R);
        sum_g_next = $signed({1'b0, y256_reg}) - $signed({1'b0, cb88_reg})
                   - $signed({1'b0, cr183_reg}) + $signed(OFFS_G);
        sum_b_next = $signed({1'b0, y256_reg}) + $signed({1'b0, cb454_reg}) - $signed(OFFS_B);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r_reg <= '0;
            sum_g_reg <= '0;
            sum_b_reg <= '0;
        end else begin
            sum_r_reg <= sum_r_next;
            sum_g_reg <= sum_g_next;
            sum_b_reg <= sum_b_next;
        end
    end

`ifdef YCBCR2RGB_DITHER_EN
    logic [1:0] pos_now;
    logic [1:0] pos_s1_reg;
    logic [1:0] pos_s2_reg;

    ycbcr2rgb_dither u_dither (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (video.pre_frame_vsync),
        .de         (video.pre_frame_de),
        .pos_lookup (pos_s2_reg),
        .pos        (pos_now),
        .off_rb     (off_rb),
        .off_g      (off_g)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_s1_reg <= '0;
            pos_s2_reg <= '0;
        end else begin
            pos_s1_reg <= pos_now;
            pos_s2_reg <= pos_s1_reg;
        end
    end
`else
    assign off_rb = '0;
    assign off_g  = '0;
`endif

    // Stage 3: clamp, dither, truncate; blanking is applied using the hsync that lands with this pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_reg   <= '0;
            green_reg <= '0;
            blue_reg  <= '0;
        end else if (ctrl_pipe[CTRL_DELAY-2].hsync) begin
            red_reg   <= to_rb5(sum_r_reg, off_rb);
            green_reg <= to_g6(sum_g_reg, off_g);
            blue_reg  <= to_rb5(sum_b_reg, off_rb);
        end else begin
            red_reg   <= '0;
            green_reg <= '0;
            blue_reg  <= '0;
        end
    end

    assign video.post_frame_vsync = ctrl_pipe[CTRL_DELAY-1].vsync;
    assign video.post_frame_hsync = ctrl_pipe[CTRL_DELAY-1].hsync;
    assign video.post_frame_de    = ctrl_pipe[CTRL_DELAY-1].de;
    assign video.img_red          = red_reg;
    assign video.img_green        = green_reg;
    assign video.img_blue         = blue_reg;

endmodule

// File: doc/ycbcr2rgb565.md
# ycbcr2rgb565

Pipelined colour-space converter that takes 8-bit YCbCr pixels and produces RGB565 with matching vsync/hsync/de timing. It is the inverse of the RGB565-to-YCbCr stage in the VIP chain: luma/chroma processing runs in YCbCr, and this block returns the result to the RGB565 LCD/display path. It uses three-stage fixed-point arithmetic with saturation. Optional 2x2 ordered dithering is applied before truncation to 565.

## Interface
- No parameters; coefficients are fixed constants.
- clk  in  1  module clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- pre_frame_vsync  in  1  input vsync
- pre_frame_hsync  in  1  input hsync
- pre_frame_de  in  1  input data enable
- img_y  in  8  luma, unsigned
- img_cb  in  8  Cb, unsigned, offset 128
- img_cr  in  8  Cr, unsigned, offset 128
- post_frame_vsync  out  1  vsync delayed 3 cycles
- post_frame_hsync  out  1  hsync delayed 3 cycles
- post_frame_de  out  1  de delayed 3 cycles
- img_red  out  5  R565
- img_green  out  6  G565
- img_blue  out  5  B565

## Operation
- Equations (×256 fixed point):
  - R = (256Y + 359Cr − 45952) >> 8
  - G = (256Y − 88Cb − 183Cr + 34688) >> 8
  - B = (256Y + 454Cb − 58112) >> 8
- Stage 1 registers the products 256Y, 359Cr, 88Cb, 183Cr and 454Cb. Products are unsigned, 17 bits wide.
- Stage 2 registers the three sums as signed 18-bit values, including the constant. Ranges are:
  - R: −45952..110873
  - G: −34417..99968
  - B: −58112..122938
- Stage 3 handles clamping and the 565 conversion:
  - A negative sum gives 0.
  - A sum ≥ 65536 gives 255.
  - Otherwise the result is sum[15:8].
  - The clamped 8-bit value is reduced to 565 (R/B keep [7:3], G keeps [7:2]). Dither offsets are added first when enabled.
- The registered stage-3 result drives the outputs.
- Control signals pass through a 3-deep shift register per signal.
- Output gating: img_red, img_green and img_blue are forced to 0 whenever post_frame_hsync is low. This matches the gating of the forward converter.
- No backpressure; the pipeline accepts one pixel every cycle.

## Timing
- Latency is exactly 3 clk cycles from input sample to output, for both data and control.
- Throughput is 1 pixel/clock.
- Reset is asynchronous and clears every pipeline register, the shift registers and the dither position state.
  - All outputs read 0 during reset and on the first cycles after it.
  - After rst_n deasserts, the outputs carry reset zeros for 3 cycles before the first valid pixel appears.
- Reset mid-frame: in-flight pixels are discarded. No partial or stale pixel appears after release.
- Boundary behaviour:
  - Saturation is applied independently per channel.
  - Exact 0 and 65535 pass unclamped.

## Configuration
- YCBCR2RGB_DITHER_EN defined: 2x2 ordered dither is applied.
  - Column parity toggles on each cycle with pre_frame_de high and clears when de is low.
  - Row parity toggles on each falling edge of pre_frame_de and clears on the rising edge of pre_frame_vsync.
  - Parity is sampled with the pixel at stage 1 and carried through the pipeline.
  - Offset by (row,col), R/B: (0,0)=0, (0,1)=4, (1,0)=6, (1,1)=2.
  - Offset by (row,col), G: (0,0)=0, (0,1)=2, (1,0)=3, (1,1)=1.
  - The offset is added to the clamped 8-bit value, saturating at 255, then truncated.
- YCBCR2RGB_DITHER_EN undefined: plain truncation. No position logic is synthesized.

## Structure
- The shared VIP header holds:
  - coefficient constants (359, 88, 183, 454)
  - offset constants (45952, 34688, 58112)
  - the control delay depth (3)
  - both dither offset tables
- Sub-module ycbcr2rgb_dither owns the row/column parity tracking and the offset lookup. It is instantiated only under YCBCR2RGB_DITHER_EN.

## Test plan
- Mid-grey, macro off: Y=Cb=Cr=128 with hsync/de high → after 3 cycles R=16, G=32, B=16.
- Positive saturation: Y=255, Cb=128, Cr=255 → R=31 (R clamped), G=41, B=31.
- Negative saturation: Y=Cb=Cr=0 → R=0, G=33, B=0.
- Control alignment: random vsync/hsync/de patterns → each output equals its input 3 cycles earlier; RGB=0 on every cycle with post_frame_hsync low.
- Reset mid-line: assert rst_n low for 1 cycle during active pixels → all outputs 0 immediately; the first new pixel appears 3 cycles after release.
- Dither, macro on: flat Y=130, Cb=Cr=128 over two lines of two pixels.
  - Row 0: R=16,16 and G=32,33.
  - Row 1: R=17,16 and G=33,32.
  - Same stimulus with the macro off: all R=16, G=32.
